// File: rtl/seg_mux_rx_if.sv
// seg_mux_rx_if: link pins and recovered-frame outputs of the seven-segment receiver.
// master = the side driving the link pins, slave = the receiver.
interface seg_mux_rx_if;
  logic [6:0] seg_in;
  logic       sel_in;
  logic       valid;
  logic [7:0] data;
  logic       err_pattern;
  logic       err_bcd;
  logic       stale;

  modport master (
    output seg_in, sel_in,
    input  valid, data, err_pattern, err_bcd, stale
  );

  modport slave (
    input  seg_in, sel_in,
    output valid, data, err_pattern, err_bcd, stale
  );
endinterface

// File: rtl/seg_mux_rx.sv
// seg_mux_rx: receive side of the two-digit multiplexed seven-segment link.
// Synchronizes the pins, waits for each digit phase to settle, decodes the
// pattern to a nibble and reassembles {high, low} into a byte with flags.
// Optional feature macro: SEG_MUX_RX_BCD_CHECK_EN (flags frames with a nibble above 9).
module seg_mux_rx #(
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input logic         clk,
  input logic         rst_n,
  seg_mux_rx_if.slave link
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  // The settle counter starts at 0 in the cycle after the edge, so it has to
  // be one short of SETTLE_CYCLES-1 when the stable cycle commits to CAPTURE.
  localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE_CYCLES - 2);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_MAX  = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    WAIT_EDGE,
    SETTLE,
    CAPTURE
  } state_t;

  // Pattern to {error, nibble}; unknown patterns decode as nibble 0 with error.
  function automatic logic [4:0] decode(input logic [6:0] seg);
    case (seg)
      7'h7E:   decode = 5'h00;
      7'h30:   decode = 5'h01;
      7'h6D:   decode = 5'h02;
      7'h79:   decode = 5'h03;
      7'h33:   decode = 5'h04;
      7'h5B:   decode = 5'h05;
      7'h5F:   decode = 5'h06;
      7'h70:   decode = 5'h07;
      7'h7F:   decode = 5'h08;
      7'h7B:   decode = 5'h09;
      7'h77:   decode = 5'h0A;
      7'h1F:   decode = 5'h0B;
      7'h4E:   decode = 5'h0C;
      7'h3D:   decode = 5'h0D;
      7'h4F:   decode = 5'h0E;
      7'h47:   decode = 5'h0F;
      default: decode = 5'h10;
    endcase
  endfunction

  // {sel, seg} through two synchronizer stages plus a one-cycle history copy.
  logic [7:0]    sync_q1, sync_q2, prev_q;
  logic          sel_s, sel_edge, seg_change, timeout_hit;
  logic [6:0]    seg_ah;
  logic [4:0]    dec;
  logic [3:0]    cur_nib;
  logic          cur_err;

  state_t        state_q, state_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic          hi_ok_q, hi_ok_d;
  logic [3:0]    hi_nib_q;
  logic          hi_err_q;
  logic          load_hi, frame_done;

  logic [TW-1:0] tcnt_q;
  logic          stale_q;
  logic          valid_q;
  logic [7:0]    data_q;
  logic          err_pattern_q;

  // Two-flop synchronizer for all eight pins, then keep last cycle's value for change detection.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
      prev_q  <= '0;
    end else begin
      sync_q1 <= {link.sel_in, link.seg_in};
      sync_q2 <= sync_q1;
      prev_q  <= sync_q2;
    end
  end

  assign sel_s       = sync_q2[7];
  assign seg_ah      = SEG_ACTIVE_LOW ? ~sync_q2[6:0] : sync_q2[6:0];
  assign sel_edge    = sync_q2[7] ^ prev_q[7];
  // Polarity does not matter for change detection, so compare the raw synchronized bits.
  assign seg_change  = (sync_q2[6:0] != prev_q[6:0]);
  // A SEL edge in the expiry cycle wins over the timeout.
  assign timeout_hit = !sel_edge && (tcnt_q == TIMEOUT_LAST);
  assign dec         = decode(seg_ah);
  assign cur_nib     = dec[3:0];
  assign cur_err     = dec[4];

  // Next-state logic: settle on each phase, capture once, pair high with low.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned and no latch is inferred.
    state_d    = state_q;
    cnt_d      = cnt_q;
    hi_ok_d    = hi_ok_q;
    load_hi    = 1'b0;
    frame_done = 1'b0;
    unique case (state_q)
      WAIT_EDGE: begin
        if (sel_edge) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end
      end
      SETTLE: begin
        if (sel_edge) begin
          cnt_d   = '0;
          hi_ok_d = 1'b0;
        end else if (seg_change) begin
          cnt_d = '0;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = CAPTURE;
        end else begin
          cnt_d = cnt_q + SW'(1);
        end
      end
      CAPTURE: begin
        // A phase that ends on the capture cycle is too short: drop it and settle the new one.
        if (sel_edge) begin
          state_d = SETTLE;
          cnt_d   = '0;
          hi_ok_d = 1'b0;
        end else begin
          state_d = WAIT_EDGE;
          if (!sel_s) begin
            load_hi = 1'b1;
            hi_ok_d = 1'b1;
          end else if (hi_ok_q) begin
            frame_done = 1'b1;
            hi_ok_d    = 1'b0;
          end
        end
      end
      default: state_d = WAIT_EDGE;
    endcase
    if (timeout_hit) begin
      state_d    = WAIT_EDGE;
      hi_ok_d    = 1'b0;
      load_hi    = 1'b0;
      frame_done = 1'b0;
    end
  end

  // FSM state, settle counter and the held high nibble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= WAIT_EDGE;
      cnt_q    <= '0;
      hi_ok_q  <= 1'b0;
      hi_nib_q <= '0;
      hi_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_ok_q <= hi_ok_d;
      if (load_hi) begin
        hi_nib_q <= cur_nib;
        hi_err_q <= cur_err;
      end
    end
  end

  // Link activity watchdog: cleared by SEL edges, saturating, drives stale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt_q  <= TIMEOUT_MAX;
      stale_q <= 1'b1;
    end else if (sel_edge) begin
      tcnt_q  <= '0;
      stale_q <= 1'b0;
    end else begin
      if (tcnt_q != TIMEOUT_MAX) tcnt_q <= tcnt_q + TW'(1);
      if (timeout_hit) stale_q <= 1'b1;
    end
  end

  // Registered frame outputs; data and pattern error hold between valid pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q       <= 1'b0;
      data_q        <= '0;
      err_pattern_q <= 1'b0;
    end else begin
      valid_q <= frame_done;
      if (frame_done) begin
        data_q        <= {hi_nib_q, cur_nib};
        err_pattern_q <= hi_err_q | cur_err;
      end
    end
  end

`ifdef SEG_MUX_RX_BCD_CHECK_EN
  logic err_bcd_q;

  // BCD range flag for the completed frame, updated together with valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_bcd_q <= 1'b0;
    end else if (frame_done) begin
      err_bcd_q <= (hi_nib_q > 4'd9) | (cur_nib > 4'd9);
    end
  end

  assign link.err_bcd = err_bcd_q;
`else
  assign link.err_bcd = 1'b0;
`endif

  assign link.valid       = valid_q;
  assign link.data        = data_q;
  assign link.err_pattern = err_pattern_q;
  assign link.stale       = stale_q;

endmodule

// File: tb/tb_seg_mux_rx.sv
// tb_seg_mux_rx: directed and randomized stimulus for seg_mux_rx, checked every
// cycle against a timing-rule model (cycles since last SEL edge / last change).
module tb_seg_mux_rx;

  localparam int S  = 16;
  localparam int T  = 400;
  localparam bit AL = 1'b1;

  localparam logic [6:0] CODES [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seg_mux_rx_if link_if ();

  seg_mux_rx #(
    .SETTLE_CYCLES (S),
    .TIMEOUT_CYCLES(T),
    .SEG_ACTIVE_LOW(AL)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .link (link_if)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [4:0] ref_decode(input logic [6:0] p);
    for (int i = 0; i < 16; i++) begin
      if (CODES[i] == p) return {1'b0, 4'(i)};
    end
    return 5'h10;
  endfunction

  // ---------------- reference model ----------------
  // A phase is captured S cycles after its last change (edge or segment change),
  // unless another edge or the timeout gets there first.
  logic [7:0] m_p1, m_p2, m_p3;
  int         m_k, m_last_edge, m_last_change;
  logic       m_armed, m_hi_ok, m_hi_err;
  logic [3:0] m_hi_nib;
  logic       e_valid, e_errp, e_errb, e_stale;
  logic [7:0] e_data;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_p1 <= '0; m_p2 <= '0; m_p3 <= '0;
      m_k <= 0; m_last_edge <= -1000000; m_last_change <= -1000000;
      m_armed <= 1'b0; m_hi_ok <= 1'b0; m_hi_err <= 1'b0; m_hi_nib <= '0;
      e_valid <= 1'b0; e_data <= '0; e_errp <= 1'b0; e_errb <= 1'b0; e_stale <= 1'b1;
    end else begin
      logic [7:0] cur, prv;
      logic       edge_now, segch;
      logic [4:0] d;
      cur      = m_p2;
      prv      = m_p3;
      edge_now = cur[7] ^ prv[7];
      segch    = (cur[6:0] != prv[6:0]);
      d        = ref_decode(AL ? ~cur[6:0] : cur[6:0]);
      e_valid <= 1'b0;
      if (edge_now) begin
        if (m_armed) m_hi_ok <= 1'b0;
        m_armed <= 1'b1;
        m_last_edge <= m_k;
        m_last_change <= m_k;
        e_stale <= 1'b0;
      end else if (m_k - m_last_edge == T) begin
        e_stale <= 1'b1;
        m_hi_ok <= 1'b0;
        m_armed <= 1'b0;
      end else if (m_armed && (m_k - m_last_change == S)) begin
        m_armed <= 1'b0;
        if (!cur[7]) begin
          m_hi_ok  <= 1'b1;
          m_hi_nib <= d[3:0];
          m_hi_err <= d[4];
        end else if (m_hi_ok) begin
          e_valid <= 1'b1;
          e_data  <= {m_hi_nib, d[3:0]};
          e_errp  <= m_hi_err | d[4];
`ifdef SEG_MUX_RX_BCD_CHECK_EN
          e_errb  <= (m_hi_nib > 4'd9) || (d[3:0] > 4'd9);
`else
          e_errb  <= 1'b0;
`endif
          m_hi_ok <= 1'b0;
        end
      end else if (m_armed && segch) begin
        m_last_change <= m_k;
      end
      m_k  <= m_k + 1;
      m_p3 <= m_p2;
      m_p2 <= m_p1;
      m_p1 <= {link_if.sel_in, link_if.seg_in};
    end
  end

  // ---------------- compare process ----------------
  int         vcount = 0;
  int         last_vcyc = 0;
  logic [7:0] last_vdata = '0;
  logic       last_errp = 1'b0;
  logic       last_errb = 1'b0;

  always @(posedge clk) begin
    #2;
    if (rst_n) begin
      check("valid", link_if.valid, e_valid);
      check("data", link_if.data, e_data);
      check("err_pattern", link_if.err_pattern, e_errp);
      check("err_bcd", link_if.err_bcd, e_errb);
      check("stale", link_if.stale, e_stale);
      if (link_if.valid) begin
        vcount++;
        last_vcyc  = cyc;
        last_vdata = link_if.data;
        last_errp  = link_if.err_pattern;
        last_errb  = link_if.err_bcd;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic s, input logic [6:0] pat);
    link_if.sel_in = s;
    link_if.seg_in = AL ? ~pat : pat;
  endtask

  task automatic phase(input logic s, input logic [6:0] pat, input int len);
    drive(s, pat);
    repeat (len) @(negedge clk);
  endtask

  task automatic phase_glitch(input logic s, input logic [6:0] pat, input int len, input int goff);
    drive(s, pat);
    repeat (goff) @(negedge clk);
    drive(s, pat ^ 7'h08);
    @(negedge clk);
    drive(s, pat);
    repeat (len - goff - 1) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         v0, t0, r, len, goff;
    logic       s, cur_sel;
    logic [6:0] pat;

    drive(1'b0, 7'h7E);
    repeat (3) @(negedge clk);
    check("reset_valid", link_if.valid, 1'b0);
    check("reset_data", link_if.data, 8'h00);
    check("reset_err_pattern", link_if.err_pattern, 1'b0);
    check("reset_err_bcd", link_if.err_bcd, 1'b0);
    check("reset_stale", link_if.stale, 1'b1);
    rst_n = 1'b1;

    // Frame 0/5 with 100-cycle phases, preceded by an orphan low phase.
    v0 = vcount;
    phase(1'b1, 7'h7E, 30);
    phase(1'b0, 7'h7E, 100);
    t0 = cyc;
    phase(1'b1, 7'h5B, 100);
    check("f05_count", vcount - v0, 1);
    check("f05_data", last_vdata, 8'h05);
    check("f05_err_pattern", last_errp, 1'b0);
    check("f05_latency", last_vcyc - t0, S + 3);

    // Frame 4/2 three times.
    v0 = vcount;
    for (int i = 0; i < 3; i++) begin
      phase(1'b0, 7'h33, 40);
      phase(1'b1, 7'h6D, 40);
    end
    check("f42_count", vcount - v0, 3);
    check("f42_data", last_vdata, 8'h42);

    // Undecodable high phase, then a clean frame clears the flag.
    phase(1'b0, 7'h01, 40);
    phase(1'b1, 7'h70, 40);
    check("bad_pat_data", last_vdata, 8'h07);
    check("bad_pat_err", last_errp, 1'b1);
    phase(1'b0, 7'h30, 40);
    phase(1'b1, 7'h6D, 40);
    check("clean_data", last_vdata, 8'h12);
    check("clean_err", last_errp, 1'b0);

    // Glitch mid-settle still captures once the lines settle again.
    v0 = vcount;
    phase_glitch(1'b0, 7'h79, 60, 8);
    phase(1'b1, 7'h7B, 40);
    check("glitch_count", vcount - v0, 1);
    check("glitch_data", last_vdata, 8'h39);

    // Short high phase, then short low phase: no output either way.
    v0 = vcount;
    phase(1'b0, 7'h7F, S - 1);
    phase(1'b1, 7'h30, 40);
    phase(1'b0, 7'h7F, 40);
    phase(1'b1, 7'h30, S - 1);
    check("short_count", vcount - v0, 0);

    // Timeout: long high phase loses its nibble; a full frame is needed afterwards.
    v0 = vcount;
    phase(1'b0, 7'h5F, T + 50);
    check("timeout_stale", link_if.stale, 1'b1);
    phase(1'b1, 7'h70, 40);
    check("timeout_recover", link_if.stale, 1'b0);
    check("timeout_nocount", vcount - v0, 0);
    phase(1'b0, 7'h7F, 40);
    phase(1'b1, 7'h30, 40);
    check("after_timeout_count", vcount - v0, 1);
    check("after_timeout_data", last_vdata, 8'h81);

    // Hex digits above 9.
    phase(1'b0, 7'h77, 40);
    phase(1'b1, 7'h79, 40);
    check("hex_data", last_vdata, 8'hA3);
`ifdef SEG_MUX_RX_BCD_CHECK_EN
    check("hex_err_bcd", last_errb, 1'b1);
`else
    check("hex_err_bcd", last_errb, 1'b0);
`endif

    // Reset in the middle of a frame discards the high nibble.
    phase(1'b0, 7'h6D, 40);
    rst_n = 1'b0;
    drive(1'b1, 7'h5B);
    repeat (3) @(negedge clk);
    check("midreset_data", link_if.data, 8'h00);
    check("midreset_stale", link_if.stale, 1'b1);
    v0 = vcount;
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("midreset_count", vcount - v0, 0);

    // Randomized phases, lengths around the settle threshold, occasional glitches.
    cur_sel = 1'b1;
    for (int i = 0; i < 150; i++) begin
      r   = $urandom_range(0, 9);
      s   = ($urandom_range(0, 7) == 0) ? cur_sel : ~cur_sel;
      pat = ($urandom_range(0, 7) == 0) ? 7'($urandom) : CODES[$urandom_range(0, 15)];
      if (r < 2)      len = $urandom_range(S - 3, S);
      else if (r < 9) len = $urandom_range(S + 1, S + 8);
      else            len = 40;
      if ($urandom_range(0, 3) == 0) begin
        goff = $urandom_range(1, len - 2);
        phase_glitch(s, pat, len, goff);
      end else begin
        phase(s, pat, len);
      end
      cur_sel = s;
    end

    repeat (40) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
